// File: rtl/as2650_wb_mailbox_if.sv
// Wishbone classic bus bundle between the Caravel management SoC and the AS2650 mailbox.
interface as2650_wb_mailbox_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/as2650_wb_mailbox.sv
// Wishbone byte mailbox between the SoC and the AS2650 core: h2c/c2h byte FIFOs plus status/IRQ.
// Optional feature: define MAILBOX_IRQ_EN to build the CTRL.IRQEN register and the user_irq[0] flop.
module as2650_mbox_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic [7:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr, rptr, cnt;
  logic [7:0]  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a byte when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  // difference taken at pointer width so it wraps cleanly before widening
  assign cnt   = wptr - rptr;
  assign count = 8'(cnt);
  assign dout  = mem[rptr[AW-1:0]];
endmodule

module as2650_wb_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  as2650_wb_mailbox_if.slave         wbs,
  output logic [7:0]                 c_rx_data,
  output logic                       c_rx_valid,
  input  logic                       c_rx_ready,
  input  logic [7:0]                 c_tx_data,
  input  logic                       c_tx_valid,
  output logic                       c_tx_ready,
  output logic [2:0]                 user_irq
);
  typedef struct packed {
    logic [1:0] off;
    logic       we;
    logic       sel0;
    logic [7:0] dat;
  } req_t;

  logic        hit, ack;
  req_t        req;
  logic        ovf;
  logic [31:0] rdata, stat, ctrl_rd;

  logic       h2c_push, h2c_pop, h2c_empty, h2c_full;
  logic [7:0] h2c_dout, h2c_cnt;
  logic       c2h_push, c2h_pop, c2h_empty, c2h_full;
  logic [7:0] c2h_dout, c2h_cnt;
  logic       wr_txd, rd_rxd, wr_stat, wr_ctrl, ovf_set;

  assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack &
               (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);

  // request is captured on the hit so the ack-cycle side effect does not depend on the master
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack <= 1'b0;
      req <= '0;
    end else begin
      ack <= hit;
      if (hit) req <= '{off: wbs.wbs_adr_i[3:2], we: wbs.wbs_we_i,
                        sel0: wbs.wbs_sel_i[0], dat: wbs.wbs_dat_i[7:0]};
    end
  end

  assign wr_txd  = ack &  req.we & (req.off == 2'd0) & req.sel0;
  assign rd_rxd  = ack & ~req.we & (req.off == 2'd1);
  assign wr_stat = ack &  req.we & (req.off == 2'd2) & req.sel0;
  assign wr_ctrl = ack &  req.we & (req.off == 2'd3) & req.sel0;

  assign h2c_push = wr_txd;
  assign h2c_pop  = c_rx_valid & c_rx_ready;
  assign c2h_push = c_tx_valid & c_tx_ready;
  assign c2h_pop  = rd_rxd;
  assign ovf_set  = wr_txd & h2c_full & ~h2c_pop;

  as2650_mbox_fifo #(.DEPTH(DEPTH)) u_h2c (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(h2c_push), .din(req.dat), .pop(h2c_pop),
    .dout(h2c_dout), .empty(h2c_empty), .full(h2c_full), .count(h2c_cnt)
  );

  as2650_mbox_fifo #(.DEPTH(DEPTH)) u_c2h (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(c2h_push), .din(c_tx_data), .pop(c2h_pop),
    .dout(c2h_dout), .empty(c2h_empty), .full(c2h_full), .count(c2h_cnt)
  );

  assign c_rx_data  = h2c_dout;
  assign c_rx_valid = ~h2c_empty;
  assign c_tx_ready = ~c2h_full;

  // a fresh overflow beats a clear landing in the same cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                      ovf <= 1'b0;
    else if (ovf_set)                  ovf <= 1'b1;
    else if (wr_stat && req.dat[4])    ovf <= 1'b0;
  end

`ifdef MAILBOX_IRQ_EN
  logic irqen, irq_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irqen <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) irqen <= req.dat[0];
      irq_q <= irqen & (~c2h_empty | ovf);
    end
  end

  assign ctrl_rd  = {31'b0, irqen};
  assign user_irq = {2'b00, irq_q};
`else
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, wr_ctrl};
  assign ctrl_rd     = '0;
  assign user_irq    = 3'b000;
`endif

  assign stat = {8'h00, c2h_cnt, h2c_cnt, 3'b000, ovf, c2h_full, c2h_empty, h2c_full, h2c_empty};

  always_comb begin
    rdata = '0;
    case (req.off)
      2'd1:    if (!c2h_empty) rdata = {23'b0, 1'b1, c2h_dout};
      2'd2:    rdata = stat;
      2'd3:    rdata = ctrl_rd;
      default: rdata = '0;
    endcase
  end

  assign wbs.wbs_ack_o = ack;
  assign wbs.wbs_dat_o = (ack & ~req.we) ? rdata : '0;

  logic unused;
  assign unused = &{1'b0, wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:8]};
endmodule

// File: tb/tb_as2650_wb_mailbox.sv
// Self-checking bench for as2650_wb_mailbox: directed scenarios plus a random op mix against queue models.
module tb_as2650_wb_mailbox;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] c_rx_data;
  logic       c_rx_valid;
  logic       c_rx_ready = 1'b0;
  logic [7:0] c_tx_data  = 8'h00;
  logic       c_tx_valid = 1'b0;
  logic       c_tx_ready;
  logic [2:0] user_irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] h2c_q[$];
  logic [7:0] c2h_q[$];
  logic       ovf_m;

  as2650_wb_mailbox_if wbs();

  as2650_wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs),
    .c_rx_data(c_rx_data), .c_rx_valid(c_rx_valid), .c_rx_ready(c_rx_ready),
    .c_tx_data(c_tx_data), .c_tx_valid(c_tx_valid), .c_tx_ready(c_tx_ready),
    .user_irq(user_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One bus transaction; waits at most 4 cycles for ack. Returns one cycle after the ack,
  // optionally holding c_rx_ready for the ack cycle so a core pop coincides with the side effect.
  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, input logic pop_on_ack,
                          output logic [31:0] rd, output logic acked);
    wbs.wbs_adr_i = adr; wbs.wbs_we_i = we; wbs.wbs_dat_i = dat; wbs.wbs_sel_i = sel;
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (wbs.wbs_ack_o) begin acked = 1'b1; rd = wbs.wbs_dat_o; end
    end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    if (pop_on_ack) c_rx_ready = 1'b1;
    @(posedge clk); #1;
    c_rx_ready = 1'b0;
  endtask

  task automatic txd_write(input logic [7:0] b, input logic pop);
    logic [31:0] rd; logic a;
    if (pop) begin
      checks++;
      if (c_rx_valid !== 1'b1 || c_rx_data !== h2c_q[0]) begin
        errors++; $display("FAIL txd_pop_head: got %b/%h exp 1/%h", c_rx_valid, c_rx_data, h2c_q[0]);
      end
    end
    wb_cycle(BASE, 1'b1, {24'h0, b}, 4'hF, pop, rd, a);
    checks++;
    if (a !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL txd_ack: ack %b dat %h exp 1/0", a, rd); end
    if (pop) void'(h2c_q.pop_front());
    if (h2c_q.size() < DEPTH) h2c_q.push_back(b);
    else ovf_m = 1'b1;
  endtask

  task automatic rxd_read(input string tag);
    logic [31:0] rd, e; logic a;
    e = (c2h_q.size() > 0) ? (32'h100 | {24'h0, c2h_q[0]}) : 32'h0;
    wb_cycle(BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, a);
    checks++;
    if (a !== 1'b1 || rd !== e) begin errors++; $display("FAIL rxd_%s: got %h ack %b exp %h", tag, rd, a, e); end
    if (c2h_q.size() > 0) void'(c2h_q.pop_front());
  endtask

  task automatic stat_read(input string tag);
    logic [31:0] rd, e; logic a;
    e = '0;
    e[0] = (h2c_q.size() == 0);
    e[1] = (h2c_q.size() == DEPTH);
    e[2] = (c2h_q.size() == 0);
    e[3] = (c2h_q.size() == DEPTH);
    e[4] = ovf_m;
    e[15:8]  = 8'(h2c_q.size());
    e[23:16] = 8'(c2h_q.size());
    wb_cycle(BASE | 32'h8, 1'b0, 32'h0, 4'hF, 1'b0, rd, a);
    checks++;
    if (a !== 1'b1 || rd !== e) begin errors++; $display("FAIL stat_%s: got %h ack %b exp %h", tag, rd, a, e); end
  endtask

  task automatic stat_clear();
    logic [31:0] rd; logic a;
    wb_cycle(BASE | 32'h8, 1'b1, 32'h10, 4'h1, 1'b0, rd, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL stat_clear_ack: got %b exp 1", a); end
    ovf_m = 1'b0;
  endtask

  task automatic core_push(input logic [7:0] b);
    checks++;
    if (c_tx_ready !== (c2h_q.size() < DEPTH)) begin
      errors++; $display("FAIL c_tx_ready: got %b exp %b", c_tx_ready, c2h_q.size() < DEPTH);
    end
    if (c2h_q.size() < DEPTH) begin
      c_tx_data = b; c_tx_valid = 1'b1;
      @(posedge clk); #1;
      c_tx_valid = 1'b0;
      c2h_q.push_back(b);
    end
  endtask

  task automatic core_pop(input string tag);
    checks++;
    if (c_rx_valid !== (h2c_q.size() > 0)) begin
      errors++; $display("FAIL c_rx_valid_%s: got %b exp %b", tag, c_rx_valid, h2c_q.size() > 0);
    end
    if (h2c_q.size() > 0) begin
      checks++;
      if (c_rx_data !== h2c_q[0]) begin errors++; $display("FAIL c_rx_data_%s: got %h exp %h", tag, c_rx_data, h2c_q[0]); end
      c_rx_ready = 1'b1;
      @(posedge clk); #1;
      c_rx_ready = 1'b0;
      void'(h2c_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    h2c_q.delete(); c2h_q.delete(); ovf_m = 1'b0;
  endtask

  task automatic test_reset();
    wbs.wbs_cyc_i = 0; wbs.wbs_stb_i = 0; wbs.wbs_we_i = 0;
    wbs.wbs_sel_i = 0; wbs.wbs_adr_i = 0; wbs.wbs_dat_i = 0;
    do_reset();
    checks++;
    if (wbs.wbs_ack_o !== 1'b0 || wbs.wbs_dat_o !== 32'h0 || user_irq !== 3'b000 ||
        c_tx_ready !== 1'b1 || c_rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ack %b dat %h irq %b txr %b rxv %b exp 0 0 0 1 0",
                         wbs.wbs_ack_o, wbs.wbs_dat_o, user_irq, c_tx_ready, c_rx_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    stat_read("reset");
  endtask

  task automatic test_reset_mid_transfer();
    core_push(8'h11);
    wbs.wbs_adr_i = BASE; wbs.wbs_we_i = 1'b1; wbs.wbs_dat_i = 32'h77; wbs.wbs_sel_i = 4'hF;
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wbs.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_mid_ack: got %b exp 0", wbs.wbs_ack_o); end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    stat_read("after_mid_reset");
  endtask

  task automatic test_h2c();
    txd_write(8'hA5, 1'b0);
    txd_write(8'h3C, 1'b0);
    stat_read("h2c_two");
    core_pop("first");
    core_pop("second");
    core_pop("empty");
    stat_read("h2c_drained");
    for (int i = 0; i < 5; i++) txd_write(8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) core_pop("rand");
  endtask

  task automatic test_c2h_full();
    logic [31:0] rd; logic a;
    for (int i = 0; i < DEPTH; i++) core_push(8'($urandom));
    core_push(8'hEE);
    stat_read("c2h_full");
    wb_cycle(BASE | 32'h4, 1'b1, 32'hFF, 4'hF, 1'b0, rd, a);
    wb_cycle(BASE, 1'b0, 32'h0, 4'hF, 1'b0, rd, a);
    checks++;
    if (a !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL txd_read: got %h ack %b exp 0", rd, a); end
    stat_read("after_rxd_write");
    for (int i = 0; i <= DEPTH; i++) rxd_read("drain");
    stat_read("c2h_drained");
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) txd_write(8'($urandom), 1'b0);
    stat_read("ovf_set");
    stat_clear();
    stat_read("ovf_cleared");
  endtask

  task automatic test_back_to_back();
    txd_write(8'($urandom), 1'b1);
    txd_write(8'($urandom), 1'b1);
    stat_read("simul_full");
    for (int i = 0; i <= DEPTH; i++) core_pop("simul_drain");
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic a;
    wb_cycle(BASE | 32'hC, 1'b1, 32'h1, 4'h1, 1'b0, rd, a);
    wb_cycle(BASE | 32'hC, 1'b0, 32'h0, 4'hF, 1'b0, rd, a);
`ifdef MAILBOX_IRQ_EN
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_read: got %h exp 1", rd); end
    checks++;
    if (user_irq !== 3'b000) begin errors++; $display("FAIL irq_idle: got %b exp 000", user_irq); end
    core_push(8'h55);
    @(posedge clk); #1;
    checks++;
    if (user_irq !== 3'b001) begin errors++; $display("FAIL irq_set: got %b exp 001", user_irq); end
    rxd_read("irq");
    @(posedge clk); #1;
    checks++;
    if (user_irq !== 3'b000) begin errors++; $display("FAIL irq_clear: got %b exp 000", user_irq); end
`else
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h exp 0", rd); end
    core_push(8'h55);
    @(posedge clk); #1;
    checks++;
    if (user_irq !== 3'b000) begin errors++; $display("FAIL irq_off: got %b exp 000", user_irq); end
    rxd_read("irq_off");
`endif
  endtask

  task automatic test_miss();
    logic [31:0] rd; logic a;
    wb_cycle(BASE | 32'h10, 1'b1, 32'h12, 4'hF, 1'b0, rd, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL miss_ack: got %b exp 0", a); end
    wb_cycle(BASE ^ 32'h1000_0000, 1'b0, 32'h0, 4'hF, 1'b0, rd, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL miss_ack_hi: got %b exp 0", a); end
    stat_read("after_miss");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       txd_write(8'($urandom), 1'b0);
        1:       rxd_read("rand");
        2:       stat_read("rand");
        3:       core_push(8'($urandom));
        4:       core_pop("rand");
        default: if (ovf_m) stat_clear(); else txd_write(8'($urandom), h2c_q.size() > 0);
      endcase
    end
    stat_read("rand_end");
  endtask

  initial begin
    test_reset();
    test_h2c();
    test_c2h_full();
    test_overflow();
    test_back_to_back();
    test_irq();
    test_miss();
    test_reset_mid_transfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
